// File: rtl/imm_gen_pipe_pkg.sv
// ============================================================================
//  Module      : imm_gen_pkg
//  Description : Opcodes, format codes and opcode classifier for imm_gen_pipe.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // The 32-bit-word opcodes are only legal on an RV64 core.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc, input bit rv64);
        fmt_e f;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:                                 f = FMT_S;
            OPC_BRANCH:                                f = FMT_B;
            OPC_LUI, OPC_AUIPC:                        f = FMT_U;
            OPC_JAL:                                   f = FMT_J;
            OPC_OP:                                    f = FMT_R;
            OPC_OPIMM32:                               f = rv64 ? FMT_I : FMT_ILL;
            OPC_OP32:                                  f = rv64 ? FMT_R : FMT_ILL;
            default:                                   f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
// ============================================================================
//  Module      : imm_gen_pipe_if
//  Description : Fetch-side and execute-side handshake bundle of imm_gen_pipe.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imm_gen_pipe_if
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;
    logic [31:0]     out_instr;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, out_instr
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, out_instr
    );

endinterface

`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
// ============================================================================
//  Module      : imm_decode_comb
//  Description : Combinational RV32I/RV64I immediate decode, sign-extend, pc+imm.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit RV64 = 1'b0
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic [XLEN-1:0] target_o,
    output logic            illegal_o
);

    logic [31:0] w_imm32;
    fmt_e        w_fmt;

    assign w_fmt = opcode_fmt(instr_i[6:0], RV64);

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: w_imm32 = {instr_i[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Every 32-bit immediate is already signed, so widening to XLEN is a plain sign-extend.
    assign imm_o     = XLEN'($signed(w_imm32));
    assign fmt_o     = w_fmt;
    assign target_o  = pc_i + imm_o;
    assign illegal_o = (w_fmt == FMT_ILL);

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : One-stage registered immediate generator with skid buffer and flush.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit RV64 = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
        logic [31:0]     instr;
    } entry_t;

    localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_R, target: '0, illegal: 1'b0, instr: '0};

    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    entry_t          out_q;
    entry_t          skid_q;
    logic            w_out_load;
    logic            w_out_from_skid;
    logic            w_skid_load;
    logic            w_accept;
    logic            w_drain;
    entry_t          w_dec;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    fmt_e            w_fmt;
    logic            w_illegal;

    imm_decode_comb #(
        .XLEN (XLEN),
        .RV64 (RV64)
    ) u_decode (
        .instr_i   (bus.in_instr),
        .pc_i      (bus.in_pc),
        .imm_o     (w_imm),
        .fmt_o     (w_fmt),
        .target_o  (w_target),
        .illegal_o (w_illegal)
    );

    always_comb begin
        w_dec.imm     = w_imm;
        w_dec.fmt     = w_fmt;
        w_dec.target  = w_target;
        w_dec.illegal = w_illegal;
        w_dec.instr   = bus.in_instr;
    end

    // Ready comes straight from the skid flag so no combinational path reaches out_ready.
    assign bus.in_ready = !skid_valid_q;
    assign w_accept     = bus.in_valid && !skid_valid_q;
    assign w_drain      = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d     = out_valid_q;
        skid_valid_d    = skid_valid_q;
        w_out_load      = 1'b0;
        w_out_from_skid = 1'b0;
        w_skid_load     = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || w_drain) begin
            if (skid_valid_q) begin
                w_out_load      = 1'b1;
                w_out_from_skid = 1'b1;
                out_valid_d     = 1'b1;
                skid_valid_d    = 1'b0;
            end else begin
                w_out_load  = w_accept;
                out_valid_d = w_accept;
            end
        end else if (w_accept) begin
            w_skid_load  = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= ENTRY_RST;
            skid_q       <= ENTRY_RST;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            if (w_out_load) begin
                out_q <= w_out_from_skid ? skid_q : w_dec;
            end
            if (w_skid_load) begin
                skid_q <= w_dec;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_target  = out_q.target;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_instr   = out_q.instr;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Directed scoreboard bench for imm_gen_pipe (XLEN=32 and XLEN=64).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic        ill;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   vectors;
    int   miscompares;
    exp_t sb32[$];
    exp_t e;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .RV64(1'b0)) u_dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .RV64(1'b1)) u_dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the instruction-format tables (XLEN=32, no RV64 opcodes).
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t r;
        r.imm = 32'h0;
        r.ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin r.fmt = 3'd1; r.imm = 32'($signed(ins[31:20])); end
            7'h23: begin r.fmt = 3'd2; r.imm = 32'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin
                r.fmt = 3'd3;
                r.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin r.fmt = 3'd4; r.imm = {ins[31:12], 12'h000}; end
            7'h6F: begin
                r.fmt = 3'd5;
                r.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h33:   r.fmt = 3'd0;
            default: begin r.fmt = 3'd7; r.ill = 1'b1; end
        endcase
        r.tgt   = pc + r.imm;
        r.instr = ins;
        return r;
    endfunction

    // Scoreboard: push on accepted input, pop on delivered output; flush/reset discard everything.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb32.delete();
        end else begin
            if (bus32.out_valid && bus32.out_ready) begin
                if (sb32.size() == 0) begin
                    chk("sb_unexpected_out", 64'(sb32.size()), 64'd1);
                end else begin
                    e = sb32.pop_front();
                    chk("sb_instr",   64'(bus32.out_instr),   64'(e.instr));
                    chk("sb_imm",     64'(bus32.out_imm),     64'(e.imm));
                    chk("sb_fmt",     64'(bus32.out_fmt),     64'(e.fmt));
                    chk("sb_target",  64'(bus32.out_target),  64'(e.tgt));
                    chk("sb_illegal", 64'(bus32.out_illegal), 64'(e.ill));
                end
            end
            if (bus32.in_valid && bus32.in_ready) begin
                sb32.push_back(model(bus32.in_instr, bus32.in_pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] eimm, input logic [2:0] efmt,
                          input logic [31:0] etgt, input logic eill);
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = ins;
        bus32.in_pc     = pc;
        bus32.out_ready = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"},   64'(bus32.out_valid),   64'd1);
        chk({tag, "_imm"},     64'(bus32.out_imm),     64'(eimm));
        chk({tag, "_fmt"},     64'(bus32.out_fmt),     64'(efmt));
        chk({tag, "_target"},  64'(bus32.out_target),  64'(etgt));
        chk({tag, "_illegal"}, 64'(bus32.out_illegal), 64'(eill));
        tick();
    endtask

    task automatic send64(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                          input logic [63:0] eimm, input logic [2:0] efmt, input logic [63:0] etgt);
        bus64.in_valid = 1'b1;
        bus64.in_instr = ins;
        bus64.in_pc    = pc;
        tick();
        bus64.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"},  64'(bus64.out_valid), 64'd1);
        chk({tag, "_imm"},    bus64.out_imm,        eimm);
        chk({tag, "_fmt"},    64'(bus64.out_fmt),   64'(efmt));
        chk({tag, "_target"}, bus64.out_target,     etgt);
        tick();
    endtask

    initial begin
        logic [31:0] tp_words [4];
        tp_words = '{32'h00100093, 32'hFE112E23, 32'h0010006F, 32'h00A58533};
        vectors     = 0;
        miscompares = 0;

        // Reset with an instruction offered throughout.
        rst             = 1'b1;
        flush           = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = 32'hFFC12083;
        bus32.in_pc     = 32'h100;
        bus32.out_ready = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.in_instr  = 32'h0;
        bus64.in_pc     = 64'h0;
        bus64.out_ready = 1'b1;
        tick();
        tick();
        rst            = 1'b0;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus32.out_valid),   64'd0);
        chk("rst_in_ready",  64'(bus32.in_ready),    64'd1);
        chk("rst_imm",       64'(bus32.out_imm),     64'd0);
        chk("rst_target",    64'(bus32.out_target),  64'd0);
        chk("rst_instr",     64'(bus32.out_instr),   64'd0);
        chk("rst_fmt",       64'(bus32.out_fmt),     64'd0);
        chk("rst_illegal",   64'(bus32.out_illegal), 64'd0);
        chk("rst64_imm",     bus64.out_imm,          64'd0);
        tick();

        // Single words, one per format.
        send32("lw",    32'hFFC12083, 32'h100,  32'hFFFFFFFC, 3'd1, 32'h000000FC, 1'b0);
        send32("beq",   32'hFE000CE3, 32'h200,  32'hFFFFFFF8, 3'd3, 32'h000001F8, 1'b0);
        send32("jal",   32'h0010006F, 32'h0,    32'h00000800, 3'd5, 32'h00000800, 1'b0);
        send32("sw",    32'hFE112E23, 32'h40,   32'hFFFFFFFC, 3'd2, 32'h0000003C, 1'b0);
        send32("lui",   32'h123450B7, 32'h1000, 32'h12345000, 3'd4, 32'h12346000, 1'b0);
        send32("ill",   32'h0000007F, 32'h50,   32'h0,        3'd7, 32'h00000050, 1'b1);
        send32("add",   32'h00A58533, 32'h60,   32'h0,        3'd0, 32'h00000060, 1'b0);
        send32("addiw", 32'hFFF0809B, 32'h70,   32'h0,        3'd7, 32'h00000070, 1'b1);

        // Backpressure: three words offered against a stalled consumer.
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = 32'h00100093;
        bus32.in_pc     = 32'h300;
        @(negedge clk);
        chk("bp_rdy_w0", 64'(bus32.in_ready), 64'd1);
        tick();
        bus32.in_instr = 32'hFE112E23;
        bus32.in_pc    = 32'h304;
        @(negedge clk);
        chk("bp_rdy_w1",   64'(bus32.in_ready),  64'd1);
        chk("bp_out_w0",   64'(bus32.out_instr), 64'h00100093);
        tick();
        bus32.in_instr = 32'h123450B7;
        bus32.in_pc    = 32'h308;
        @(negedge clk);
        chk("bp_rdy_full", 64'(bus32.in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("bp_hold_rdy",   64'(bus32.in_ready),   64'd0);
        chk("bp_hold_instr", 64'(bus32.out_instr),  64'h00100093);
        chk("bp_hold_imm",   64'(bus32.out_imm),    64'd1);
        chk("bp_hold_tgt",   64'(bus32.out_target), 64'h301);
        tick();
        bus32.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_w0", 64'(bus32.out_instr), 64'h00100093);
        tick();
        @(negedge clk);
        chk("bp_drain_w1_valid", 64'(bus32.out_valid), 64'd1);
        chk("bp_drain_w1",       64'(bus32.out_instr), 64'hFE112E23);
        chk("bp_rdy_back",       64'(bus32.in_ready),  64'd1);
        tick();
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain_w2_valid", 64'(bus32.out_valid), 64'd1);
        chk("bp_drain_w2",       64'(bus32.out_instr), 64'h123450B7);
        tick();
        @(negedge clk);
        chk("bp_empty", 64'(bus32.out_valid), 64'd0);
        tick();

        // Flush with both entries full and a word offered, consumer ready.
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = 32'h00A58533;
        bus32.in_pc     = 32'h400;
        tick();
        bus32.in_instr = 32'h0000007F;
        tick();
        bus32.in_instr = 32'h0010006F;
        @(negedge clk);
        chk("fl_full", 64'(bus32.in_ready), 64'd0);
        tick();
        flush           = 1'b1;
        bus32.out_ready = 1'b1;
        tick();
        flush          = 1'b0;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("fl_in_ready",  64'(bus32.in_ready),  64'd1);
        tick();

        // Flush with only the output entry full, input accepted-looking that same edge.
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = 32'h00A58533;
        tick();
        bus32.in_instr = 32'h0010006F;
        flush          = 1'b1;
        tick();
        flush          = 1'b0;
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        chk("fl1_out_valid", 64'(bus32.out_valid), 64'd0);
        tick();
        tick();
        @(negedge clk);
        chk("fl1_stays_empty", 64'(bus32.out_valid), 64'd0);
        tick();

        // Full throughput: one word per cycle, no bubbles.
        bus32.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus32.in_valid = 1'b1;
            bus32.in_instr = tp_words[k];
            bus32.in_pc    = 32'h800 + 32'(k * 4);
            @(negedge clk);
            chk("tp_in_ready", 64'(bus32.in_ready), 64'd1);
            if (k > 0) begin
                chk("tp_out_valid", 64'(bus32.out_valid), 64'd1);
                chk("tp_out_instr", 64'(bus32.out_instr), 64'(tp_words[k-1]));
            end
            tick();
        end
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("tp_last", 64'(bus32.out_instr), 64'(tp_words[3]));
        tick();

        // XLEN=64 with RV64 opcodes enabled.
        send64("lui64",   32'h800000B7, 64'h1000, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80001000);
        send64("addiw64", 32'hFFF0809B, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h0000000000001FFF);
        send64("addw64",  32'h00B5053B, 64'h3000, 64'h0,                3'd0, 64'h0000000000003000);

        tick();
        tick();
        chk("sb_drained", 64'(sb32.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate generator.
- Decodes all RV32I/RV64I immediate formats (I, S, B, U, J) and sign-extends to XLEN.
- Also computes pc+imm and flags illegal opcodes.
- Sits between fetch and execute behind a valid/ready handshake, with one registered stage, a skid buffer and flush.

Parameters:
- XLEN, 32, datapath width for immediate, PC and target (legal values 32 or 64).
- RV64, 0, when 1 also accepts OP-IMM-32 (0011011) as I-type; must be 0 when XLEN=32.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drops all buffered entries; this cycle's input is ignored.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code (see Decomposition).
- out_target  out  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_illegal  out  1  opcode not recognised.
- out_instr  out  32  instruction passed through.

Behaviour:
- Format by opcode[6:0]:
  - I: 0000011, 0010011, 1100111, 1110011, plus 0011011 if RV64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111. R: 0110011, plus 0111011 if RV64.
  - Anything else: ILL.
- Immediate:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U = sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 copy instr[31].
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R and ILL give 0.
- out_illegal=1 only for ILL. out_target is always pc+imm; the consumer decides whether to use it.
- Transfers: input when in_valid && in_ready; output when out_valid && out_ready.
- Latency: one cycle. A word accepted at edge N is presented with out_valid=1 after edge N.
- Storage is two entries: output register plus skid register.
- in_ready is driven only from a register: in_ready = !skid_valid. It never depends combinationally on out_ready.
- Capture rules, per edge:
  - Output register empty, or draining this edge: the input goes to the output register.
  - Output register full and stalled, input accepted: the input goes to the skid register, which then becomes full.
  - Output drains while the skid is full: skid moves to the output register and the skid empties.
- Full-throughput case: with out_ready held 1, one word per cycle passes with no bubbles.
- Stall case: with out_ready held 0, the block accepts exactly 2 words, then in_ready=0.
- Stall stability: while out_valid && !out_ready, all out_* fields are held stable.
- Flush:
  - At the edge, out_valid and skid_valid are cleared.
  - A simultaneous in_valid is dropped.
  - A simultaneous out_ready has no effect: the entry counts as flushed, not delivered.
- Flush and rst together behave as rst.
- Reset:
  - out_valid=0 and skid_valid=0, so in_ready=1 from the cycle after the reset edge.
  - out_imm, out_target, out_instr = 0; out_fmt = FMT_R; out_illegal = 0.
  - Reset mid-stall discards both entries.
- Data registers load only on capture; no toggling while empty.

Decomposition:
- Package imm_gen_pkg:
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OPIMM32, OPC_OP32.
  - 3-bit fmt enum: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_ILL=7.
- One natural sub-module, imm_decode_comb:
  - Purely combinational: instr and pc in; imm, fmt, target and illegal out.
- The top level holds the two-entry skid/handshake logic.

Test Plan:
- Reset with in_valid=1 held → out_valid=0 and in_ready=1 on the first post-reset cycle; all out_* zero, out_fmt=FMT_R.
- lw x1,-4(x2) = 0xFFC12083 at pc=0x100, XLEN=32 → next cycle out_imm=0xFFFFFFFC, fmt=I, target=0x000000FC.
- beq with imm=-8 = 0xFE000CE3 at pc=0x200 → imm=0xFFFFFFF8, fmt=B, target=0x1F8.
- jal with imm=+2048 = 0x0010006F → imm=0x800.
- XLEN=64: lui x1,0x80000 = 0x800000B7 → imm=0xFFFFFFFF80000000, fmt=U.
- Backpressure: out_ready=0 while 3 back-to-back words are offered → accept 2, then in_ready=0. With out_ready then held 1, words come out in order on consecutive cycles and in_ready returns to 1.
- Flush while both entries are full, with in_valid=1 and out_ready=1 → next cycle out_valid=0, in_ready=1, and neither the flushed entries nor the offered word are ever delivered.
- Opcode 0x7F → out_illegal=1, fmt=ILL, imm=0. 0x00A58533 (add) → fmt=R, imm=0, illegal=0.
